// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Streaming RV32I instruction encoder. Takes instruction fields plus a
//   signed immediate, validates the immediate for the selected format, packs
//   the 32-bit instruction word and presents it with its load address through
//   a single registered output stage (valid/ready on both sides).
//
// Ports
//   clk, rst (async, active-high), clear (sync, same effect as rst)
//   in_valid/in_ready      request handshake
//   in_fmt                 0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm
//   out_valid/out_ready    result handshake
//   out_instr, out_addr    encoded word and its load address
//   err, err_code          sticky error flag and first error cause
//   word_count, err_count  emitted words (wraps), rejects (saturates)
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       word_count,
    output logic [7:0]        err_count
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_FMT   = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_RANGE = 2'b11;

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(3'd4);

    // Field packing for every legal format; unused fields are simply dropped.
    function automatic logic [31:0] f_pack(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        case (fmt)
            FMT_R:   f_pack = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   f_pack = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   f_pack = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   f_pack = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   f_pack = {imm[31:12], rd, op};
            FMT_J:   f_pack = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: f_pack = 32'h0000_0000;
        endcase
    endfunction

    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic [ADDR_W-1:0] r_next_addr;
    logic              r_err;
    logic [1:0]        r_err_code;
    logic [15:0]       r_word_count;
    logic [7:0]        r_err_count;

    logic       w_in_hs;
    logic       w_out_hs;
    logic       w_fits_12;   // sign-extension of a 12-bit immediate
    logic       w_fits_13;   // sign-extension of a 13-bit branch offset
    logic       w_fits_21;   // sign-extension of a 21-bit jump offset
    logic [1:0] w_cause;
    logic       w_load;
    logic       w_reject;

    assign in_ready = !r_out_valid || out_ready;
    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = r_out_valid && out_ready;

    assign w_fits_12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign w_fits_13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
    assign w_fits_21 = (&in_imm[31:20]) || !(|in_imm[31:20]);

    // Immediate validation; earlier checks take priority over later ones.
    always_comb begin
        w_cause = ERR_NONE;
        if (in_fmt > FMT_J) begin
            w_cause = ERR_FMT;
        end else if (((in_fmt == FMT_B) || (in_fmt == FMT_J)) && in_imm[0]) begin
            w_cause = ERR_ALIGN;
        end else if ((in_fmt == FMT_U) && (in_imm[11:0] != 12'h000)) begin
            w_cause = ERR_ALIGN;
        end else if (((in_fmt == FMT_I) || (in_fmt == FMT_S)) && !w_fits_12) begin
            w_cause = ERR_RANGE;
        end else if ((in_fmt == FMT_B) && !w_fits_13) begin
            w_cause = ERR_RANGE;
        end else if ((in_fmt == FMT_J) && !w_fits_21) begin
            w_cause = ERR_RANGE;
        end else begin
            w_cause = ERR_NONE;
        end
    end

    assign w_load   = w_in_hs && (w_cause == ERR_NONE);
    assign w_reject = w_in_hs && (w_cause != ERR_NONE);

    // Output stage, address generator and status counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_instr  <= 32'h0000_0000;
            r_out_addr   <= BASE_ADDR;
            r_next_addr  <= BASE_ADDR;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_word_count <= 16'd0;
            r_err_count  <= 8'd0;
        end else if (clear) begin
            r_out_valid  <= 1'b0;
            r_out_instr  <= 32'h0000_0000;
            r_out_addr   <= BASE_ADDR;
            r_next_addr  <= BASE_ADDR;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_word_count <= 16'd0;
            r_err_count  <= 8'd0;
        end else begin
            if (w_out_hs) begin
                r_word_count <= r_word_count + 16'd1;
            end
            // A rejected request still frees the stage if the held word left.
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_instr <= f_pack(in_fmt, in_opcode, in_funct3, in_funct7,
                                      in_rd, in_rs1, in_rs2, in_imm);
                r_out_addr  <= r_next_addr;
                r_next_addr <= r_next_addr + ADDR_STEP;
            end else if (w_reject || w_out_hs) begin
                r_out_valid <= 1'b0;
            end
            if (w_reject) begin
                r_err <= 1'b1;
                if (!r_err) begin
                    r_err_code <= w_cause;
                end
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_instr  = r_out_instr;
    assign out_addr   = r_out_addr;
    assign err        = r_err;
    assign err_code   = r_err_code;
    assign word_count = r_word_count;
    assign err_count  = r_err_count;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: the inverse of the core's immediate decode path. It accepts instruction fields (format, opcode, funct3/funct7, register indices, 32-bit signed immediate), validates the immediate against the format's range and alignment, packs the 32-bit instruction word, and presents it with its target load address. It feeds the instruction-memory program loader and self-check benches.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: load address of the first emitted word.
- `ADDR_W`, default 32: width of `out_addr`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous clear, same effect as reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `in_fmt`  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
- `in_opcode`  in  7  placed in bits [6:0].
- `in_funct3`  in  3  bits [14:12] (R/I/S/B only).
- `in_funct7`  in  7  bits [31:25] (R only).
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_imm`  in  32  signed immediate, byte offset for B/J, full value for U.
- `out_valid`  out  1  encoded word valid.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `out_instr`  out  32  encoded instruction.
- `out_addr`  out  ADDR_W  load address of `out_instr`.
- `err`  out  1  sticky: any rejected request since reset/clear.
- `err_code`  out  2  first error cause: 01 illegal fmt, 10 misaligned, 11 out of range.
- `word_count`  out  16  emitted words, wraps.
- `err_count`  out  8  rejected requests, saturates at 255.

## Operation
- Field packing:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Fields unused by a format are ignored.
- Validation, checked in priority order:
  - Illegal fmt: `in_fmt` is 6 or 7.
  - Misaligned: B/J with imm[0]=1, or U with imm[11:0]≠0.
  - Range: I/S need imm[31:11] all equal; B needs imm[31:12] all equal; J needs imm[31:20] all equal.
  - R is never rejected.
- Rejected request:
  - Consumed normally; no word emitted; `next_addr` unchanged.
  - `err_count` increments (saturating); `err` set.
  - `err_code` is written only if `err` was 0.
- Accepted legal request: word loaded into the output register; `out_addr` takes `next_addr`; `next_addr` advances by 4, wrapping modulo 2^ADDR_W.
- `word_count` increments on each output handshake.

## Timing
- Single output register stage, one-cycle latency: request accepted at edge N appears with `out_valid`=1 after edge N.
- `in_ready = !out_valid || out_ready`, combinational; full throughput of one word per cycle.
- Under backpressure (`out_valid && !out_ready`), `out_instr`/`out_addr` hold stable and `in_ready`=0.
- Simultaneous output handshake and input handshake:
  - Legal input: the register reloads and `out_valid` stays 1.
  - Rejected input: `out_valid` falls to 0.
- Reset and `clear`:
  - Reset values: `out_valid`=0, `out_instr`=0, `out_addr`=BASE_ADDR, `next_addr`=BASE_ADDR, `err`=0, `err_code`=0, `word_count`=0, `err_count`=0; `in_ready`=1 one cycle after.
  - `clear` overrides any simultaneous handshake; the in-flight word is dropped and not counted.
  - Reset mid-stream drops the held word.

## Test plan
- ADDI x1,x0,5 (fmt I, opcode 0x13) -> `out_instr`=0x00500093, `out_addr`=0x0, `word_count`=1 after handshake.
- SW x2,8(x1), then BEQ x0,x0,-4, back-to-back with `out_ready`=1 -> 0x0020A423 @0x0, then 0xFE000EE3 @0x4, one per cycle.
- JAL x1,2048, then LUI x5 with imm 0x12345000 -> 0x001000EF, then 0x123452B7.
- Rejections:
  - I-type imm 2048 -> no output, `err`=1, `err_code`=11, `err_count`=1.
  - Then B-type imm 3 -> `err_code` stays 11, `err_count`=2.
  - Then fmt 7 -> `err_count`=3.
  - Next legal word lands at the unadvanced address.
- Hold `out_ready`=0 for 5 cycles with `in_valid`=1 -> `in_ready`=0, outputs stable; release -> queued request accepted the same cycle, no loss or duplication.
- Assert `clear`, then separately `rst`, mid-stream with an output pending -> all outputs at reset values, next word at BASE_ADDR.
